sw_event_logger: RTL and testbench
==================================

# sw_event_logger

Event logger directly downstream of the stopwatch. It consumes the stopwatch's single-cycle start/stop/clear/save event strobes and the live time value. Each event is captured as a timestamped record in a small first-word-fall-through FIFO, and records are handed to a consumer (UART formatter) over a valid/ready handshake. Events that cannot be stored are counted, not silently lost.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, ≥2
- ADDR_W, 3, log2(DEPTH); must be kept consistent with DEPTH

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_event_start  in  1  stopwatch run start strobe (1 cycle)
- i_event_stop  in  1  stopwatch stop strobe (1 cycle)
- i_event_clear  in  1  stopwatch clear strobe
- i_event_save  in  1  stopwatch lap-save strobe
- i_msec  in  7  live time, centiseconds 0..99
- i_sec  in  6  live time, seconds 0..59
- i_min  in  6  live time, minutes 0..59
- i_hour  in  5  live time, hours 0..23
- o_rec_valid  out  1  head record available
- i_rec_ready  in  1  consumer accepts head record this cycle
- o_rec_code  out  2  head event code: 00 start, 01 stop, 10 clear, 11 save
- o_rec_time  out  24  head timestamp {hour[4:0], min[5:0], sec[5:0], msec[6:0]}
- o_count  out  ADDR_W+1  records currently stored, 0..DEPTH
- o_full  out  1  o_count == DEPTH
- o_drop_cnt  out  8  saturating count of discarded events
- i_drop_clr  in  1  clears o_drop_cnt

## Operation
- Capture: any strobe high in cycle N forms one record. The record uses the time inputs sampled in cycle N and is written at the rising edge ending cycle N.
- Priority when several strobes are high in one cycle: clear > stop > start > save. One record is written per cycle. Each lower-priority strobe that was also high adds 1 to o_drop_cnt.
- Full: with o_full=1 and no pop in the same cycle, the event is discarded and o_drop_cnt increments.
- Simultaneous push and pop when full: the pop frees a slot and the push is accepted; o_count stays DEPTH.
- Simultaneous push and pop otherwise: o_count is unchanged.
- Pop: occurs when o_rec_valid & i_rec_ready. The head advances and the next record (if any) is presented the following cycle. i_rec_ready while empty has no effect.
- o_drop_cnt:
  - Saturates at 255.
  - i_drop_clr forces 0.
  - If i_drop_clr and a drop occur in the same cycle, the result is 0 (clear wins).
- Pointers are ADDR_W bits and wrap modulo DEPTH. Occupancy is tracked by the ADDR_W+1-bit count.
- Time inputs are stored without range checking.
- Reset values:
  - o_rec_valid=0, o_count=0, o_full=0, o_drop_cnt=0
  - o_rec_code=00, o_rec_time=0
  - pointers=0
  - FIFO storage contents are don't-care.
- Reset asserted mid-operation empties the FIFO on that edge. Strobes coinciding with rst are ignored.

## Timing
- Event-to-valid latency, FIFO empty: strobe in cycle N → o_rec_valid=1 with that record in cycle N+1.
- o_rec_code, o_rec_time, o_rec_valid, o_count, o_full and o_drop_cnt are registered outputs with no combinational path from inputs.
- Pop takes effect at the edge. With ≥2 records stored, a continuous i_rec_ready drains one record per cycle.
- o_rec_code and o_rec_time stay stable while o_rec_valid=1 and i_rec_ready=0.
- Throughput: one event accepted per cycle.

## Configuration
- SWLOG_TIMESTAMP_EN defined: timestamps are stored as described, giving 26-bit FIFO entries.
- SWLOG_TIMESTAMP_EN undefined:
  - Only the 2-bit code is stored.
  - o_rec_time is tied to 0.
  - Time inputs are unused.
  - All handshake, priority, drop and count behaviour is identical.

## Test plan
- Reset, then a start strobe at time 0:00:05.42 → next cycle o_rec_valid=1, code 00, o_rec_time={0,0,5,42}, o_count=1. Pop with ready → o_rec_valid=0 the following cycle.
- Start, stop, save, clear on four consecutive cycles with ready=0 → o_count=4. Drain with ready=1 → codes 00, 01, 11, 10 in order, one per cycle.
- Clear, stop and save high in the same cycle → single record with code 10; o_drop_cnt=2.
- Fill 8 records with ready=0, then a ninth event → o_full=1, o_drop_cnt=1, count 8. Next event with ready=1 in the same cycle → accepted; oldest record popped; count stays 8.
- 300 events while full → o_drop_cnt saturates at 255. i_drop_clr together with a drop → 0.
- Assert rst with 5 records stored and a strobe in the same cycle → o_count=0, o_rec_valid=0 next cycle, no record written. Build without SWLOG_TIMESTAMP_EN → o_rec_time=0 on all records.

Source files
------------

// File: rtl/sw_event_logger_if.sv
// Record handshake between the event logger (master) and its consumer (slave).
interface sw_event_logger_if;
  logic        o_rec_valid;
  logic        i_rec_ready;
  logic [1:0]  o_rec_code;
  logic [23:0] o_rec_time;

  modport master (output o_rec_valid, output o_rec_code, output o_rec_time, input i_rec_ready);
  modport slave  (input o_rec_valid, input o_rec_code, input o_rec_time, output i_rec_ready);
endinterface

// File: rtl/sw_event_logger.sv
// Stopwatch event logger: strobes become timestamped records in a FWFT FIFO.
// Define SWLOG_TIMESTAMP_EN to store timestamps; otherwise only event codes are kept.
module sw_event_logger #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_event_start,
  input  logic              i_event_stop,
  input  logic              i_event_clear,
  input  logic              i_event_save,
  input  logic [6:0]        i_msec,
  input  logic [5:0]        i_sec,
  input  logic [5:0]        i_min,
  input  logic [4:0]        i_hour,
  sw_event_logger_if.master rec,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic [7:0]        o_drop_cnt,
  input  logic              i_drop_clr
);

`ifdef SWLOG_TIMESTAMP_EN
  localparam int ENTRY_W = 26;
`else
  localparam int ENTRY_W = 2;
`endif

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]    r_count;
  logic               r_full, r_rec_valid;
  logic [1:0]         r_rec_code;
  logic [7:0]         r_drop_cnt;

  logic [1:0]         w_code;
  logic [ENTRY_W-1:0] w_din, w_head;
  logic [2:0]         w_nstrobe, w_drop_inc;
  logic               w_any, w_pop, w_push;
  logic [8:0]         w_drop_sum;
  logic [7:0]         w_drop_next;
  logic [ADDR_W-1:0]  w_rd_next;
  logic [ADDR_W:0]    w_count_next;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_code = 2'b00;
    if (i_event_clear)      w_code = 2'b10;
    else if (i_event_stop)  w_code = 2'b01;
    else if (i_event_start) w_code = 2'b00;
    else if (i_event_save)  w_code = 2'b11;

    w_nstrobe = 3'(i_event_start) + 3'(i_event_stop) + 3'(i_event_clear) + 3'(i_event_save);
    w_any     = !rst && (w_nstrobe != 3'd0);
    w_pop     = r_rec_valid && rec.i_rec_ready;
    w_push    = w_any && (!r_full || w_pop);

    // Losers of the priority race plus a record refused by a full FIFO.
    w_drop_inc = 3'd0;
    if (w_any) w_drop_inc = w_nstrobe - 3'd1 + 3'(!w_push);
    w_drop_sum  = {1'b0, r_drop_cnt} + 9'(w_drop_inc);
    w_drop_next = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    if (i_drop_clr) w_drop_next = 8'h00;

    w_rd_next    = r_rd_ptr + ADDR_W'(w_pop);
    w_count_next = r_count + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);

    // Bypass a record written straight into the head slot so latency stays one cycle.
    w_head = (w_push && (w_rd_next == r_wr_ptr)) ? w_din : r_mem[w_rd_next];
  end

`ifdef SWLOG_TIMESTAMP_EN
  logic [23:0] r_rec_time;
  assign w_din = {w_code, i_hour, i_min, i_sec, i_msec};
`else
  assign w_din = w_code;
  logic w_unused_time;
  assign w_unused_time = ^{i_hour, i_min, i_sec, i_msec};
`endif

  // NOTE: storage has no reset; its contents are don't-care until a pointer covers them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_din;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_rec_valid <= 1'b0;
      r_rec_code  <= 2'b00;
      r_drop_cnt  <= 8'h00;
`ifdef SWLOG_TIMESTAMP_EN
      r_rec_time  <= '0;
`endif
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      r_rd_ptr    <= w_rd_next;
      r_count     <= w_count_next;
      r_full      <= (w_count_next == (ADDR_W+1)'(DEPTH));
      r_rec_valid <= (w_count_next != '0);
      r_drop_cnt  <= w_drop_next;
      if (w_count_next != '0) begin
        r_rec_code <= w_head[ENTRY_W-1 -: 2];
`ifdef SWLOG_TIMESTAMP_EN
        r_rec_time <= w_head[23:0];
`endif
      end
    end
  end

  assign rec.o_rec_valid = r_rec_valid;
  assign rec.o_rec_code  = r_rec_code;
`ifdef SWLOG_TIMESTAMP_EN
  assign rec.o_rec_time  = r_rec_time;
`else
  assign rec.o_rec_time  = 24'h0;
`endif
  assign o_count    = r_count;
  assign o_full     = r_full;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_sw_event_logger.sv
// Scoreboard bench for sw_event_logger: records queued on capture, compared on pop.
module tb_sw_event_logger;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ev_start, ev_stop, ev_clear, ev_save, drop_clr;
  logic [6:0] msec;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic [3:0] count;
  logic       full;
  logic [7:0] drop_cnt;

  sw_event_logger_if rec_if ();

  sw_event_logger #(.DEPTH(DEPTH), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .i_event_start(ev_start), .i_event_stop(ev_stop),
    .i_event_clear(ev_clear), .i_event_save(ev_save),
    .i_msec(msec), .i_sec(sec), .i_min(min), .i_hour(hour),
    .rec(rec_if.master),
    .o_count(count), .o_full(full), .o_drop_cnt(drop_cnt),
    .i_drop_clr(drop_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [25:0] exp_q [$];
  int exp_drop = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, score pop/push against the model, check after the edge.
  task automatic cycle(input logic [3:0] stb, input logic rdy, input logic clr,
                       input logic r, input logic [23:0] t);
    int n;
    int drops;
    logic [1:0]  code;
    logic [25:0] head;
    {ev_clear, ev_stop, ev_start, ev_save} = stb;
    rec_if.i_rec_ready = rdy;
    drop_clr = clr;
    rst = r;
    {hour, min, sec, msec} = t;
    #1;
    check("valid_pre", 32'(rec_if.o_rec_valid), 32'(exp_q.size() > 0));
    n = int'(stb[0]) + int'(stb[1]) + int'(stb[2]) + int'(stb[3]);
    if (r) begin
      exp_q.delete();
      exp_drop = 0;
    end else begin
      if (rdy && exp_q.size() > 0) begin
        head = exp_q.pop_front();
        check("pop_code", 32'(rec_if.o_rec_code), 32'(head[25:24]));
        check("pop_time", 32'(rec_if.o_rec_time), 32'(head[23:0]));
      end
      drops = 0;
      if (n > 0) begin
        drops = n - 1;
        if (stb[3])      code = 2'b10;
        else if (stb[2]) code = 2'b01;
        else if (stb[1]) code = 2'b00;
        else             code = 2'b11;
        if (exp_q.size() < DEPTH) begin
`ifdef SWLOG_TIMESTAMP_EN
          exp_q.push_back({code, t});
`else
          exp_q.push_back({code, 24'h0});
`endif
        end else begin
          drops++;
        end
      end
      if (clr) exp_drop = 0;
      else     exp_drop = (exp_drop + drops > 255) ? 255 : exp_drop + drops;
    end
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(exp_q.size()));
    check("full", 32'(full), 32'(exp_q.size() == DEPTH));
    check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    check("valid", 32'(rec_if.o_rec_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check("head_code", 32'(rec_if.o_rec_code), 32'(exp_q[0][25:24]));
      check("head_time", 32'(rec_if.o_rec_time), 32'(exp_q[0][23:0]));
    end
  endtask

  function automatic logic [23:0] rand_time();
    logic [4:0] h;
    logic [5:0] m, s;
    logic [6:0] c;
    h = 5'($urandom_range(23));
    m = 6'($urandom_range(59));
    s = 6'($urandom_range(59));
    c = 7'($urandom_range(99));
    return {h, m, s, c};
  endfunction

  localparam logic [3:0] S_CLEAR = 4'b1000, S_STOP = 4'b0100, S_START = 4'b0010, S_SAVE = 4'b0001;

  initial begin
    {ev_start, ev_stop, ev_clear, ev_save, drop_clr} = '0;
    rec_if.i_rec_ready = 1'b0;
    {hour, min, sec, msec} = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(rec_if.o_rec_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_code", 32'(rec_if.o_rec_code), 32'd0);
    check("rst_time", 32'(rec_if.o_rec_time), 32'd0);

    // Start at 0:00:05.42, then pop it.
    cycle(S_START, 1'b0, 1'b0, 1'b0, {5'd0, 6'd0, 6'd5, 7'd42});
    cycle(4'b0, 1'b1, 1'b0, 1'b0, 24'h0);

    // Four events back to back, then drain.
    cycle(S_START, 1'b0, 1'b0, 1'b0, rand_time());
    cycle(S_STOP,  1'b0, 1'b0, 1'b0, rand_time());
    cycle(S_SAVE,  1'b0, 1'b0, 1'b0, rand_time());
    cycle(S_CLEAR, 1'b0, 1'b0, 1'b0, rand_time());
    repeat (4) cycle(4'b0, 1'b1, 1'b0, 1'b0, 24'h0);

    // Priority: clear+stop+save gives one clear record and two drops.
    cycle(S_CLEAR | S_STOP | S_SAVE, 1'b0, 1'b0, 1'b0, rand_time());
    cycle(4'b0, 1'b1, 1'b1, 1'b0, 24'h0);

    // Fill, overflow by one, then push with a simultaneous pop while full.
    repeat (DEPTH + 1) cycle(S_SAVE, 1'b0, 1'b0, 1'b0, rand_time());
    cycle(S_STOP, 1'b1, 1'b0, 1'b0, rand_time());

    // Saturate the drop counter, then clear it against a drop.
    repeat (300) cycle(S_START, 1'b0, 1'b0, 1'b0, rand_time());
    cycle(S_START, 1'b0, 1'b1, 1'b0, rand_time());

    // Drain, store five, then reset with a coinciding strobe.
    repeat (DEPTH + 1) cycle(4'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    repeat (5) cycle(S_STOP, 1'b0, 1'b0, 1'b0, rand_time());
    cycle(S_CLEAR, 1'b0, 1'b0, 1'b1, rand_time());
    cycle(4'b0, 1'b1, 1'b0, 1'b0, 24'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(4'($urandom_range(15)) & (($urandom_range(2) == 0) ? 4'hF : 4'h0),
            1'($urandom_range(1)), ($urandom_range(30) == 0), 1'b0, rand_time());
    repeat (DEPTH + 1) cycle(4'b0, 1'b1, 1'b0, 1'b0, 24'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
